// File: rtl/talco_xdrop_pkg.sv
// Purpose: shared types for the TALCO-XDrop tile termination logic.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package talco_xdrop_pkg;

    // Why a tile stopped; encoding is visible on the term_reason port.
    typedef enum logic [1:0] {
        TERM_NONE  = 2'd0,
        TERM_XDROP = 2'd1,
        TERM_CONV  = 2'd2,
        TERM_END   = 2'd3
    } term_reason_e;

    // Termination monitor control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } xmon_state_e;

endpackage

// File: rtl/xdrop_term_monitor.sv
// Purpose: tracks the tile best score/position and applies X-drop, convergence and end-of-tile termination.
// Latency: one cycle from an antidiagonal beat to updated best/count and to done/stop.
// Backpressure: none; accepts one beat per cycle, stop is the only throttle back to the PE array.
module xdrop_term_monitor
    import talco_xdrop_pkg::*;
#(
    parameter int PE_WIDTH   = 16,
    parameter int SEL_WIDTH  = 16,
    parameter int LOG_NUM_PE = 2,
    parameter int CONV_WIDTH = 16,
    parameter int AD_WIDTH   = 16,
    parameter int CONV_RUN   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic        [PE_WIDTH-1:0]   x_drop,
    input  logic                         ad_valid,
    input  logic signed [PE_WIDTH-1:0]   ad_max,
    input  logic        [LOG_NUM_PE-1:0] ad_idx,
    input  logic        [SEL_WIDTH-1:0]  ad_sel,
    input  logic                         ad_last,
    input  logic                         conv_bool,
    input  logic        [CONV_WIDTH-1:0] conv_value,
    output logic                         busy,
    output logic                         stop,
    output logic                         done,
    output logic        [1:0]            term_reason,
    output logic signed [PE_WIDTH-1:0]   best_score,
    output logic        [LOG_NUM_PE-1:0] best_idx,
    output logic        [SEL_WIDTH-1:0]  best_sel,
    output logic        [AD_WIDTH-1:0]   best_ad,
    output logic        [AD_WIDTH-1:0]   ad_count,
    output logic        [CONV_WIDTH-1:0] conv_out
);

    localparam int CNT_W = $clog2(CONV_RUN + 1);
    localparam logic [CNT_W-1:0] CONV_RUN_C = CNT_W'(CONV_RUN);

    xmon_state_e           state;
    xmon_state_e           state_nxt;
    logic                  first;
    logic [PE_WIDTH-1:0]   x_drop_q;
    logic [CNT_W-1:0]      conv_cnt;
    logic [CNT_W-1:0]      conv_cnt_nxt;
    logic                  beat;
    logic                  best_upd;
    logic                  drop_hit;
    logic                  conv_hit;
    logic                  term;
    term_reason_e          reason_nxt;
    // Two guard bits: ad_max + x_drop spans the signed minimum up to
    // max-positive plus a full-range unsigned threshold, so the sum never wraps.
    logic signed [PE_WIDTH+1:0] drop_lhs;
    logic signed [PE_WIDTH+1:0] drop_rhs;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Beat qualification, best/X-drop/convergence decisions and next state.
    always_comb begin
        beat         = (state == ST_RUN) && ad_valid && !start;
        drop_lhs     = {{2{ad_max[PE_WIDTH-1]}}, ad_max} + {2'b00, x_drop_q};
        drop_rhs     = {{2{best_score[PE_WIDTH-1]}}, best_score};
        drop_hit     = beat && !first && (drop_lhs < drop_rhs);
        best_upd     = beat && (first || (ad_max > best_score));
        conv_cnt_nxt = '0;
        if (conv_bool && (conv_value != '0)) begin
            conv_cnt_nxt = (conv_cnt == CONV_RUN_C) ? conv_cnt : conv_cnt + 1'b1;
        end
        conv_hit     = beat && (conv_cnt_nxt == CONV_RUN_C);
        term         = drop_hit || conv_hit || (beat && ad_last);
        reason_nxt   = TERM_NONE;
        if (drop_hit) begin
            reason_nxt = TERM_XDROP;
        end else if (conv_hit) begin
            reason_nxt = TERM_CONV;
        end else if (beat && ad_last) begin
            reason_nxt = TERM_END;
        end
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else if ((state == ST_RUN) && term) begin
            state_nxt = ST_DONE;
        end
    end

    // Result registers: cleared by start, updated per beat, frozen once done.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            stop        <= 1'b0;
            done        <= 1'b0;
            term_reason <= 2'd0;
            best_score  <= '0;
            best_idx    <= '0;
            best_sel    <= '0;
            best_ad     <= '0;
            ad_count    <= '0;
            conv_out    <= '0;
            conv_cnt    <= '0;
            first       <= 1'b0;
            x_drop_q    <= '0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt == ST_RUN);
            if (start) begin
                stop        <= 1'b0;
                term_reason <= 2'd0;
                best_score  <= '0;
                best_idx    <= '0;
                best_sel    <= '0;
                best_ad     <= '0;
                ad_count    <= '0;
                conv_out    <= '0;
                conv_cnt    <= '0;
                first       <= 1'b1;
                x_drop_q    <= x_drop;
            end else if (beat) begin
                first    <= 1'b0;
                conv_cnt <= conv_cnt_nxt;
                if (ad_count != '1) begin
                    ad_count <= ad_count + 1'b1;
                end
                if (best_upd) begin
                    best_score <= ad_max;
                    best_idx   <= ad_idx;
                    best_sel   <= ad_sel;
                    best_ad    <= ad_count;
                end
                if (conv_hit) begin
                    conv_out <= conv_value;
                end
                if (term) begin
                    done        <= 1'b1;
                    stop        <= 1'b1;
                    term_reason <= reason_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_xdrop_term_monitor.sv
// Purpose: directed self-checking bench for xdrop_term_monitor.
// Latency: inputs driven on falling edge, results sampled one falling edge later.
// Backpressure: none exercised; beats are driven back to back.
module tb_xdrop_term_monitor;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic        [15:0] x_drop = '0;
    logic               ad_valid = 1'b0;
    logic signed [15:0] ad_max = '0;
    logic        [1:0]  ad_idx = '0;
    logic        [15:0] ad_sel = '0;
    logic               ad_last = 1'b0;
    logic               conv_bool = 1'b0;
    logic        [15:0] conv_value = '0;
    logic               busy;
    logic               stop;
    logic               done;
    logic        [1:0]  term_reason;
    logic signed [15:0] best_score;
    logic        [1:0]  best_idx;
    logic        [15:0] best_sel;
    logic        [15:0] best_ad;
    logic        [15:0] ad_count;
    logic        [15:0] conv_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xdrop_term_monitor #(
        .PE_WIDTH(16), .SEL_WIDTH(16), .LOG_NUM_PE(2),
        .CONV_WIDTH(16), .AD_WIDTH(16), .CONV_RUN(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x_drop(x_drop),
        .ad_valid(ad_valid), .ad_max(ad_max), .ad_idx(ad_idx), .ad_sel(ad_sel),
        .ad_last(ad_last), .conv_bool(conv_bool), .conv_value(conv_value),
        .busy(busy), .stop(stop), .done(done), .term_reason(term_reason),
        .best_score(best_score), .best_idx(best_idx), .best_sel(best_sel),
        .best_ad(best_ad), .ad_count(ad_count), .conv_out(conv_out)
    );

    // Called on a falling edge; returns on the falling edge after the capture.
    task automatic do_start(input logic [15:0] xd);
        start  = 1'b1;
        x_drop = xd;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic do_beat(input logic signed [15:0] mx, input logic [1:0] idx,
                           input logic [15:0] sel, input logic last,
                           input logic cb, input logic [15:0] cv);
        ad_valid   = 1'b1;
        ad_max     = mx;
        ad_idx     = idx;
        ad_sel     = sel;
        ad_last    = last;
        conv_bool  = cb;
        conv_value = cv;
        @(negedge clk);
        ad_valid   = 1'b0;
        ad_last    = 1'b0;
        conv_bool  = 1'b0;
        conv_value = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, stop, done, term_reason} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy/stop/done/reason=%b required 00000", {busy, stop, done, term_reason});
        end
        checks++;
        if ({best_score, best_idx, best_sel, best_ad, ad_count, conv_out} !== 82'b0) begin
            errors++;
            $display("FAIL reset_data: got best=%0d ad_count=%0d conv_out=%0d required all zero", best_score, ad_count, conv_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_xdrop;
        do_start(16'd10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL xdrop_busy: got %b required 1", busy);
        end
        do_beat(16'sd5, 2'd2, 16'h0040, 1'b0, 1'b0, 16'd0);
        checks++;
        if (best_score !== 16'sd5 || best_ad !== 16'd0 || ad_count !== 16'd1 || best_idx !== 2'd2) begin
            errors++;
            $display("FAIL xdrop_first: got best=%0d ad=%0d cnt=%0d idx=%0d required 5 0 1 2", best_score, best_ad, ad_count, best_idx);
        end
        do_beat(16'sd12, 2'd1, 16'h0099, 1'b0, 1'b0, 16'd0);
        do_beat(16'sd8, 2'd3, 16'h0011, 1'b0, 1'b0, 16'd0);
        do_beat(16'sd3, 2'd0, 16'h0022, 1'b0, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b0 || stop !== 1'b0 || ad_count !== 16'd4) begin
            errors++;
            $display("FAIL xdrop_pre: got done=%b stop=%b cnt=%0d required 0 0 4", done, stop, ad_count);
        end
        do_beat(16'sd1, 2'd0, 16'h0033, 1'b0, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b1 || stop !== 1'b1 || busy !== 1'b0 || term_reason !== 2'd1) begin
            errors++;
            $display("FAIL xdrop_term: got done=%b stop=%b busy=%b reason=%0d required 1 1 0 1", done, stop, busy, term_reason);
        end
        checks++;
        if (best_score !== 16'sd12 || best_ad !== 16'd1 || ad_count !== 16'd5 || best_idx !== 2'd1 || best_sel !== 16'h0099) begin
            errors++;
            $display("FAIL xdrop_result: got best=%0d ad=%0d cnt=%0d idx=%0d sel=%h required 12 1 5 1 0099", best_score, best_ad, ad_count, best_idx, best_sel);
        end
        do_beat(16'sd50, 2'd0, 16'h0000, 1'b0, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b0 || stop !== 1'b1 || ad_count !== 16'd5 || best_score !== 16'sd12) begin
            errors++;
            $display("FAIL xdrop_hold: got done=%b stop=%b cnt=%0d best=%0d required 0 1 5 12", done, stop, ad_count, best_score);
        end
    endtask

    task automatic test_threshold;
        do_start(16'd10);
        do_beat(16'sd12, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        do_beat(16'sd2, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL thresh_equal: got done=%b busy=%b required 0 1", done, busy);
        end
        do_beat(16'sd1, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b1 || term_reason !== 2'd1) begin
            errors++;
            $display("FAIL thresh_below: got done=%b reason=%0d required 1 1", done, term_reason);
        end
    endtask

    task automatic test_conv;
        do_start(16'd100);
        do_beat(16'sd0, 2'd0, 16'd0, 1'b0, 1'b1, 16'd7);
        do_beat(16'sd0, 2'd0, 16'd0, 1'b0, 1'b0, 16'd7);
        do_beat(16'sd0, 2'd0, 16'd0, 1'b0, 1'b1, 16'd7);
        checks++;
        if (done !== 1'b0 || conv_out !== 16'd0) begin
            errors++;
            $display("FAIL conv_broken_run: got done=%b conv_out=%0d required 0 0", done, conv_out);
        end
        do_beat(16'sd0, 2'd0, 16'd0, 1'b0, 1'b1, 16'd7);
        checks++;
        if (done !== 1'b1 || term_reason !== 2'd2 || conv_out !== 16'd7 || ad_count !== 16'd4) begin
            errors++;
            $display("FAIL conv_term: got done=%b reason=%0d conv_out=%0d cnt=%0d required 1 2 7 4", done, term_reason, conv_out, ad_count);
        end
        do_start(16'd100);
        checks++;
        if (conv_out !== 16'd0 || stop !== 1'b0 || term_reason !== 2'd0) begin
            errors++;
            $display("FAIL conv_restart_clear: got conv_out=%0d stop=%b reason=%0d required 0 0 0", conv_out, stop, term_reason);
        end
        do_beat(16'sd0, 2'd0, 16'd0, 1'b0, 1'b1, 16'd0);
        do_beat(16'sd0, 2'd0, 16'd0, 1'b0, 1'b1, 16'd0);
        do_beat(16'sd0, 2'd0, 16'd0, 1'b0, 1'b1, 16'd0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL conv_zero_value: got done=%b busy=%b required 0 1", done, busy);
        end
    endtask

    task automatic test_simultaneous;
        do_start(16'd10);
        do_beat(16'sd12, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        do_beat(16'sd1, 2'd0, 16'd0, 1'b1, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b1 || term_reason !== 2'd1) begin
            errors++;
            $display("FAIL simul_xdrop_last: got done=%b reason=%0d required 1 1", done, term_reason);
        end
        do_start(16'd10);
        do_beat(16'sd12, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        do_beat(16'sd5, 2'd0, 16'd0, 1'b1, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b1 || term_reason !== 2'd3 || ad_count !== 16'd2) begin
            errors++;
            $display("FAIL simul_end: got done=%b reason=%0d cnt=%0d required 1 3 2", done, term_reason, ad_count);
        end
    endtask

    task automatic test_overflow;
        do_start(16'd100);
        do_beat(-16'sd32700, 2'd1, 16'h0a0a, 1'b0, 1'b0, 16'd0);
        do_beat(-16'sd32767, 2'd2, 16'h0b0b, 1'b0, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b0 || best_score !== -16'sd32700) begin
            errors++;
            $display("FAIL ovf_negative: got done=%b best=%0d required 0 -32700", done, best_score);
        end
        do_beat(-16'sd32700, 2'd3, 16'h0c0c, 1'b0, 1'b0, 16'd0);
        checks++;
        if (best_ad !== 16'd0 || best_idx !== 2'd1 || best_sel !== 16'h0a0a || ad_count !== 16'd3) begin
            errors++;
            $display("FAIL ovf_tie: got ad=%0d idx=%0d sel=%h cnt=%0d required 0 1 0a0a 3", best_ad, best_idx, best_sel, ad_count);
        end
        do_start(16'hFFFF);
        do_beat(16'sd32767, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        do_beat(16'sd32767, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        do_beat(-16'sd32768, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || best_score !== 16'sd32767) begin
            errors++;
            $display("FAIL ovf_wide_threshold: got done=%b busy=%b best=%0d required 0 1 32767", done, busy, best_score);
        end
    endtask

    task automatic test_abort;
        do_start(16'd10);
        do_beat(16'sd5, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        do_beat(16'sd6, 2'd0, 16'd0, 1'b0, 1'b0, 16'd0);
        start    = 1'b1;
        x_drop   = 16'd10;
        ad_valid = 1'b1;
        ad_max   = 16'sd7;
        @(negedge clk);
        start    = 1'b0;
        ad_valid = 1'b0;
        checks++;
        if (ad_count !== 16'd0 || best_score !== 16'sd0 || done !== 1'b0 || busy !== 1'b1 || stop !== 1'b0) begin
            errors++;
            $display("FAIL abort_restart: got cnt=%0d best=%0d done=%b busy=%b stop=%b required 0 0 0 1 0", ad_count, best_score, done, busy, stop);
        end
        do_beat(-16'sd3, 2'd2, 16'd0, 1'b0, 1'b0, 16'd0);
        checks++;
        if (best_score !== -16'sd3 || best_ad !== 16'd0 || ad_count !== 16'd1) begin
            errors++;
            $display("FAIL abort_first_again: got best=%0d ad=%0d cnt=%0d required -3 0 1", best_score, best_ad, ad_count);
        end
        do_beat(16'sd9, 2'd1, 16'd0, 1'b0, 1'b0, 16'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, stop, done, term_reason} !== 5'b0 || best_score !== 16'sd0 || ad_count !== 16'd0) begin
            errors++;
            $display("FAIL abort_rst: got busy/stop/done/reason=%b best=%0d cnt=%0d required 00000 0 0", {busy, stop, done, term_reason}, best_score, ad_count);
        end
        do_beat(16'sd20, 2'd0, 16'd0, 1'b1, 1'b0, 16'd0);
        checks++;
        if (ad_count !== 16'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_ignore: got cnt=%0d done=%b busy=%b required 0 0 0", ad_count, done, busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_xdrop();
        test_threshold();
        test_conv();
        test_simultaneous();
        test_overflow();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
